// File: rtl/rgb_conv_pkg.sv
// ----------------------------------------------------------------------------
// rgb_conv_pkg
//   Shared constants for the RGB conv-layer datapath: the default sample
//   width, the packed widths derived from it, and a helper that sizes the
//   pixel/row counters.
//   No ports (package).
// ----------------------------------------------------------------------------
package rgb_conv_pkg;

  localparam int DATA_WIDTH_DFLT = 8;
  localparam int COL_W           = 3 * DATA_WIDTH_DFLT;  // one channel, three rows
  localparam int PIX_W           = 3 * DATA_WIDTH_DFLT;  // one pixel, three channels
  localparam int CONV_OUT_W      = 2 * DATA_WIDTH_DFLT + 6;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb_line_buffer.sv
// ----------------------------------------------------------------------------
// rgb_line_buffer
//   One image row of packed RGB pixels. A single address serves both the
//   read and the write port: the read is combinational so the caller sees the
//   old contents in the same cycle it overwrites them.
//   Contents are never reset; every entry is rewritten before it is used.
// Ports
//   clk    in  1      clock
//   we     in  1      write enable
//   addr   in  AW     shared read/write address (pixel x)
//   wdata  in  WIDTH  data written at the rising edge when we=1
//   rdata  out WIDTH  current contents at addr
// ----------------------------------------------------------------------------
module rgb_line_buffer
  import rgb_conv_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = PIX_W,
  localparam int AW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/rgb_column_feeder.sv
// ----------------------------------------------------------------------------
// rgb_column_feeder
//   Turns a raster-order RGB pixel stream into vertical 3-pixel columns per
//   channel for the 3x3 systolic conv layer. Two line buffers keep rows y-1
//   and y-2; each accepted pixel produces one column {y-2, y-1, y} (MSB = top)
//   once the bottom row index reaches 2. A single output register with no
//   skid stage: a new pixel is taken only if the column slot is empty or is
//   being retired in the same cycle.
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   pix_valid/pix_ready      input handshake
//   pix_r/pix_g/pix_b        input samples
//   col_valid/col_ready      output handshake
//   input_col_r/g/b          column per channel, {row y-2, row y-1, row y}
//   col_x, col_y             column position (col_y = bottom row)
//   col_last                 column at (IMG_WIDTH-1, IMG_HEIGHT-1)
// ----------------------------------------------------------------------------
module rgb_column_feeder
  import rgb_conv_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter  int IMG_WIDTH  = 64,
  parameter  int IMG_HEIGHT = 64,
  localparam int X_W        = cnt_w(IMG_WIDTH),
  localparam int Y_W        = cnt_w(IMG_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [DATA_WIDTH-1:0]   pix_r,
  input  logic [DATA_WIDTH-1:0]   pix_g,
  input  logic [DATA_WIDTH-1:0]   pix_b,
  output logic                    col_valid,
  input  logic                    col_ready,
  output logic [3*DATA_WIDTH-1:0] input_col_r,
  output logic [3*DATA_WIDTH-1:0] input_col_g,
  output logic [3*DATA_WIDTH-1:0] input_col_b,
  output logic [X_W-1:0]          col_x,
  output logic [Y_W-1:0]          col_y,
  output logic                    col_last
);

  localparam int             DW     = DATA_WIDTH;
  localparam int             PW     = 3 * DATA_WIDTH;
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic            col_valid_q, col_valid_d;
  logic [3*DW-1:0] col_r_q, col_r_d;
  logic [3*DW-1:0] col_g_q, col_g_d;
  logic [3*DW-1:0] col_b_q, col_b_d;
  logic [X_W-1:0]  col_x_q, col_x_d;
  logic [Y_W-1:0]  col_y_q, col_y_d;
  logic            col_last_q, col_last_d;

  logic            accept;
  logic [PW-1:0]   pix_cat;
  logic [PW-1:0]   lb1_rdata;  // row y-1 at x
  logic [PW-1:0]   lb2_rdata;  // row y-2 at x

  // Gated by rst so nothing is taken while the block is held in reset.
  assign pix_ready = rst & (~col_valid_q | col_ready);
  assign accept    = pix_valid & pix_ready;
  assign pix_cat   = {pix_r, pix_g, pix_b};

  // Both buffers shift down one row on every accept: lb2 takes what lb1 held,
  // lb1 takes the new pixel. Reads return the pre-write contents.
  rgb_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PW)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (x_q),
    .wdata (pix_cat),
    .rdata (lb1_rdata)
  );

  rgb_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PW)
  ) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (x_q),
    .wdata (lb1_rdata),
    .rdata (lb2_rdata)
  );

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    col_valid_d = col_valid_q;
    col_r_d     = col_r_q;
    col_g_d     = col_g_q;
    col_b_d     = col_b_q;
    col_x_d     = col_x_q;
    col_y_d     = col_y_q;
    col_last_d  = col_last_q;

    if (accept) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end

      col_r_d     = {lb2_rdata[3*DW-1 -: DW], lb1_rdata[3*DW-1 -: DW], pix_r};
      col_g_d     = {lb2_rdata[2*DW-1 -: DW], lb1_rdata[2*DW-1 -: DW], pix_g};
      col_b_d     = {lb2_rdata[DW-1:0],       lb1_rdata[DW-1:0],       pix_b};
      col_x_d     = x_q;
      col_y_d     = y_q;
      col_last_d  = (x_q == X_LAST) && (y_q == Y_LAST);
      // Rows 0 and 1 only fill the line buffers.
      col_valid_d = (y_q > Y_W'(1));
    end else if (col_ready) begin
      col_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q         <= '0;
      y_q         <= '0;
      col_valid_q <= 1'b0;
      col_r_q     <= '0;
      col_g_q     <= '0;
      col_b_q     <= '0;
      col_x_q     <= '0;
      col_y_q     <= '0;
      col_last_q  <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      col_valid_q <= col_valid_d;
      col_r_q     <= col_r_d;
      col_g_q     <= col_g_d;
      col_b_q     <= col_b_d;
      col_x_q     <= col_x_d;
      col_y_q     <= col_y_d;
      col_last_q  <= col_last_d;
    end
  end

  assign col_valid   = col_valid_q;
  assign input_col_r = col_r_q;
  assign input_col_g = col_g_q;
  assign input_col_b = col_b_q;
  assign col_x       = col_x_q;
  assign col_y       = col_y_q;
  assign col_last    = col_last_q;

endmodule

// File: tb/tb_rgb_column_feeder.sv
// ----------------------------------------------------------------------------
// tb_rgb_column_feeder
//   Directed bench for rgb_column_feeder at 4x4 images, 8-bit samples.
//   Pixel(x,y) of a frame with base b: R=b+4y+x, G=R+32, B=R+64.
// ----------------------------------------------------------------------------
module tb_rgb_column_feeder;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] pix_r = '0;
  logic [DW-1:0] pix_g = '0;
  logic [DW-1:0] pix_b = '0;
  logic          col_valid;
  logic          col_ready = 1'b0;
  logic [23:0]   input_col_r, input_col_g, input_col_b;
  logic [1:0]    col_x, col_y;
  logic          col_last;

  int checks = 0;
  int errors = 0;

  rgb_column_feeder #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b),
    .col_valid   (col_valid),
    .col_ready   (col_ready),
    .input_col_r (input_col_r),
    .input_col_g (input_col_g),
    .input_col_b (input_col_b),
    .col_x       (col_x),
    .col_y       (col_y),
    .col_last    (col_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] r;
    logic [23:0] g;
    logic [23:0] b;
    logic        last;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pval(input int base, input int ch, input int x, input int y);
    return 8'(base + 4 * y + x + 32 * ch);
  endfunction

  function automatic logic [23:0] ecol(input int base, input int ch, input int x, input int y);
    return {pval(base, ch, x, y - 2), pval(base, ch, x, y - 1), pval(base, ch, x, y)};
  endfunction

  task automatic drive_pix(input int base, input int x, input int y);
    pix_r = pval(base, 0, x, y);
    pix_g = pval(base, 1, x, y);
    pix_b = pval(base, 2, x, y);
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b0;
    pix_valid = 1'b0;
    col_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rst_ready"}, pix_ready,   1'b0);
    chk({tag, "_rst_valid"}, col_valid,   1'b0);
    chk({tag, "_rst_r"},     input_col_r, 24'h0);
    chk({tag, "_rst_g"},     input_col_g, 24'h0);
    chk({tag, "_rst_b"},     input_col_b, 24'h0);
    chk({tag, "_rst_x"},     col_x,       2'd0);
    chk({tag, "_rst_y"},     col_y,       2'd0);
    chk({tag, "_rst_last"},  col_last,    1'b0);
    @(posedge clk); #1;
    rst       = 1'b1;
    col_ready = 1'b0;
  endtask

  // One frame at full rate, every column compared with the hand-computed table.
  task automatic run_table(input string tag);
    int k     = 0;
    int ncol  = 0;
    int nlast = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        pix_valid = 1'b1;
        col_ready = 1'b1;
        drive_pix(0, x, y);
        #1;
        chk($sformatf("%s_ready_%0d_%0d", tag, x, y), pix_ready, 1'b1);
        @(posedge clk); #1;
        if (col_valid) ncol++;
        if (col_valid && col_last) nlast++;
        if (y >= 2) begin
          chk($sformatf("%s_valid%0d", tag, k), col_valid,   1'b1);
          chk($sformatf("%s_r%0d", tag, k),     input_col_r, tbl[k].r);
          chk($sformatf("%s_g%0d", tag, k),     input_col_g, tbl[k].g);
          chk($sformatf("%s_b%0d", tag, k),     input_col_b, tbl[k].b);
          chk($sformatf("%s_x%0d", tag, k),     col_x,       tbl[k].x);
          chk($sformatf("%s_y%0d", tag, k),     col_y,       tbl[k].y);
          chk($sformatf("%s_last%0d", tag, k),  col_last,    tbl[k].last);
          k++;
        end else begin
          chk($sformatf("%s_novalid_%0d_%0d", tag, x, y), col_valid, 1'b0);
        end
      end
    end
    pix_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_cleared"}, col_valid, 1'b0);
    chk({tag, "_ncols"},   ncol,      8);
    chk({tag, "_nlast"},   nlast,     1);
    col_ready = 1'b0;
  endtask

  // Cycle-level stream with a behavioural model of the handshake; column data
  // is predicted from the pixel formula. Optional hold of col_ready on one
  // column, optional random gaps on both sides.
  task automatic run_stream(input string tag, input int nframes, input int base_step,
                            input bit rnd, input int hold_x, input int hold_y,
                            input int hold_n, output int ncols,
                            output logic [23:0] hold_r, output logic [23:0] after_r,
                            output logic [23:0] f1_r);
    int px = 0, py = 0, fr = 0, sent = 0, budget = 3000, hold_left = hold_n;
    int total = nframes * W * H;
    int m_x = 0, m_y = 0, m_fr = 0;
    bit m_valid = 0, m_last = 0, pv, cr, acc, held, hold_prev;
    bit was_held = 0, got_after = 0, got_f1 = 0;
    logic [23:0] m_r = '0, m_g = '0, m_b = '0;
    ncols = 0; hold_r = '0; after_r = '0; f1_r = '0;
    while ((sent < total || m_valid) && budget > 0) begin
      pv   = (sent < total) && (!rnd || $urandom_range(0, 3) != 0);
      cr   = !rnd || $urandom_range(0, 3) != 0;
      held = 0;
      if (m_valid && m_x == hold_x && m_y == hold_y && hold_left > 0) begin
        cr = 0;
        hold_left--;
        held = 1;
        was_held = 1;
      end
      pix_valid = pv;
      col_ready = cr;
      drive_pix(fr * base_step, px, py);
      #1;
      chk({tag, "_ready"}, pix_ready, !m_valid || cr);
      acc       = pv && (!m_valid || cr);
      hold_prev = m_valid && !cr;
      if (m_valid && cr) ncols++;
      @(posedge clk); #1;
      if (acc) begin
        m_valid = (py >= 2);
        m_x     = px;
        m_y     = py;
        m_fr    = fr;
        m_last  = (px == W - 1) && (py == H - 1);
        m_r     = ecol(fr * base_step, 0, px, py);
        m_g     = ecol(fr * base_step, 1, px, py);
        m_b     = ecol(fr * base_step, 2, px, py);
        sent++;
        if (px == W - 1) begin
          px = 0;
          if (py == H - 1) begin
            py = 0;
            fr++;
          end else begin
            py++;
          end
        end else begin
          px++;
        end
      end else if (cr) begin
        m_valid = 0;
      end
      chk({tag, "_valid"}, col_valid, m_valid);
      if (hold_prev) chk({tag, "_nodrop"}, col_valid, 1'b1);
      if (m_valid) begin
        chk({tag, "_r"},    input_col_r, m_r);
        chk({tag, "_g"},    input_col_g, m_g);
        chk({tag, "_b"},    input_col_b, m_b);
        chk({tag, "_x"},    col_x,       m_x);
        chk({tag, "_y"},    col_y,       m_y);
        chk({tag, "_last"}, col_last,    m_last);
      end
      if (held) hold_r = input_col_r;
      if (was_held && !got_after && m_valid && !(m_x == hold_x && m_y == hold_y)) begin
        after_r   = input_col_r;
        got_after = 1;
      end
      if (!got_f1 && m_valid && m_fr == 1) begin
        f1_r   = input_col_r;
        got_f1 = 1;
      end
      budget--;
    end
    pix_valid = 1'b0;
    col_ready = 1'b0;
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d pixels sent required=%0d", tag, sent, total);
    end
  endtask

  initial begin
    int          nc;
    logic [23:0] hr, ar, f1;

    tbl[0] = '{0, 2, 24'h000408, 24'h202428, 24'h404448, 1'b0};
    tbl[1] = '{1, 2, 24'h010509, 24'h212529, 24'h414549, 1'b0};
    tbl[2] = '{2, 2, 24'h02060A, 24'h22262A, 24'h42464A, 1'b0};
    tbl[3] = '{3, 2, 24'h03070B, 24'h23272B, 24'h43474B, 1'b0};
    tbl[4] = '{0, 3, 24'h04080C, 24'h24282C, 24'h44484C, 1'b0};
    tbl[5] = '{1, 3, 24'h05090D, 24'h25292D, 24'h45494D, 1'b0};
    tbl[6] = '{2, 3, 24'h060A0E, 24'h262A2E, 24'h464A4E, 1'b0};
    tbl[7] = '{3, 3, 24'h070B0F, 24'h272B2F, 24'h474B4F, 1'b1};

    // 1) one frame, full rate
    do_reset("t1");
    run_table("t1");

    // 2) back-pressure on column (1,2)
    do_reset("t2");
    run_stream("t2", 1, 0, 1'b0, 1, 2, 3, nc, hr, ar, f1);
    chk("t2_ncols",    nc, 8);
    chk("t2_hold_r",   hr, 24'h010509);
    chk("t2_after_r",  ar, 24'h02060A);

    // 3) two back-to-back frames, second frame offset by 100
    do_reset("t3");
    run_stream("t3", 2, 100, 1'b0, -1, -1, 0, nc, hr, ar, f1);
    chk("t3_ncols",    nc, 16);
    chk("t3_f1_first", f1, 24'h64686C);

    // 4) reset right after pixel (2,2), then a clean frame
    do_reset("t4");
    col_ready = 1'b1;
    pix_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive_pix(0, i % W, i / W);
      @(posedge clk); #1;
    end
    chk("t4_pre_valid", col_valid,   1'b1);
    chk("t4_pre_r",     input_col_r, 24'h02060A);
    rst       = 1'b0;
    pix_valid = 1'b0;
    #1;
    chk("t4_rst_ready", pix_ready, 1'b0);
    @(posedge clk); #1;
    chk("t4_mid_valid", col_valid,   1'b0);
    chk("t4_mid_r",     input_col_r, 24'h0);
    chk("t4_mid_g",     input_col_g, 24'h0);
    chk("t4_mid_x",     col_x,       2'd0);
    chk("t4_mid_y",     col_y,       2'd0);
    rst = 1'b1;
    run_table("t4");

    // 5) random gaps on both handshakes over three frames
    do_reset("t5");
    run_stream("t5", 3, 50, 1'b1, -1, -1, 0, nc, hr, ar, f1);
    chk("t5_ncols", nc, 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
